display_seq_ctrl: RTL and testbench

DISPLAY_SEQ_CTRL -- requirements
Module: display_seq_ctrl

---
 rtl/display_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_display_seq_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_seq_ctrl.sv
// Game-over display sequencer: fades the board out, shows the "you died" overlay
// until a restart is pending, then fades the board back in and hands control back.
module display_seq_ctrl #(
    parameter int FADE_STEP   = 2,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       frame_start,
    input  logic       game_over,
    input  logic       restart,
    output logic       overlay_on,
    output logic [3:0] fade_level,
    output logic       in_play,
    output logic       board_clear,
    output logic       restart_ack
);
    localparam logic [3:0] STEP_LAST   = 4'(FADE_STEP - 1);
    localparam logic [7:0] HOLD_MAX    = 8'(HOLD_FRAMES);
    localparam logic [3:0] LEVEL_FULL  = 4'd15;
    localparam logic [3:0] LEVEL_BLACK = 4'd0;

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        FADE_OUT  = 3'd1,
        DIED_IN   = 3'd2,
        DIED_HOLD = 3'd3,
        DIED_OUT  = 3'd4,
        PLAY_IN   = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] fade_r, fade_s;
    logic [3:0] step_cnt_r, step_cnt_s, step_adv_s;
    logic [7:0] hold_cnt_r, hold_cnt_s;
    logic       overlay_r, overlay_s;
    logic       pend_r, pend_s;
    logic       in_play_r, in_play_s;
    logic       board_clear_r, board_clear_s;
    logic       ack_r, ack_s;
    logic       fading_s, step_evt_s, pending_s;

    // Next-state and next-output logic; everything only moves on frame_start
    always_comb begin
        state_s       = state_r;
        fade_s        = fade_r;
        hold_cnt_s    = hold_cnt_r;
        overlay_s     = overlay_r;
        board_clear_s = 1'b0;
        ack_s         = 1'b0;

        fading_s   = (state_r == FADE_OUT) || (state_r == DIED_IN) ||
                     (state_r == DIED_OUT) || (state_r == PLAY_IN);
        step_evt_s = frame_start && fading_s && (step_cnt_r == STEP_LAST);
        pending_s  = pend_r | restart;

        if (frame_start && fading_s) begin
            step_adv_s = step_evt_s ? 4'd0 : (step_cnt_r + 4'd1);
        end else begin
            step_adv_s = step_cnt_r;
        end

        if (restart && ((state_r == FADE_OUT) || (state_r == DIED_IN) ||
                        (state_r == DIED_HOLD))) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_r;
        end

        case (state_r)
            PLAY: begin
                overlay_s = 1'b0;
                fade_s    = LEVEL_FULL;
                if (frame_start && game_over) begin
                    state_s = FADE_OUT;
                end else begin
                    state_s = PLAY;
                end
            end
            FADE_OUT, DIED_OUT: begin
                if (step_evt_s) begin
                    if (fade_r != LEVEL_BLACK) begin
                        fade_s = fade_r - 4'd1;
                    end else if (state_r == FADE_OUT) begin
                        state_s   = DIED_IN;
                        overlay_s = 1'b1;
                    end else begin
                        state_s       = PLAY_IN;
                        overlay_s     = 1'b0;
                        board_clear_s = 1'b1;
                    end
                end else begin
                    fade_s = fade_r;
                end
            end
            DIED_IN, PLAY_IN: begin
                if (step_evt_s) begin
                    if (fade_r != LEVEL_FULL) begin
                        fade_s = fade_r + 4'd1;
                    end else if (state_r == DIED_IN) begin
                        state_s    = DIED_HOLD;
                        hold_cnt_s = 8'd0;
                    end else begin
                        state_s = PLAY;
                        ack_s   = 1'b1;
                    end
                end else begin
                    fade_s = fade_r;
                end
            end
            DIED_HOLD: begin
                overlay_s = 1'b1;
                fade_s    = LEVEL_FULL;
                if (frame_start) begin
                    if ((hold_cnt_r == HOLD_MAX) && pending_s) begin
                        state_s = DIED_OUT;
                        pend_s  = 1'b0;
                    end else if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_s = hold_cnt_r;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s   = PLAY;
                fade_s    = LEVEL_FULL;
                overlay_s = 1'b0;
                pend_s    = 1'b0;
            end
        endcase

        // The step phase restarts whenever a new state is entered
        step_cnt_s = (state_s != state_r) ? 4'd0 : step_adv_s;
        in_play_s  = (state_s == PLAY);
    end

    // State and output registers with synchronous clear
    always_ff @(posedge dclk) begin
        if (clr) begin
            state_r       <= PLAY;
            fade_r        <= LEVEL_FULL;
            step_cnt_r    <= 4'd0;
            hold_cnt_r    <= 8'd0;
            overlay_r     <= 1'b0;
            pend_r        <= 1'b0;
            in_play_r     <= 1'b1;
            board_clear_r <= 1'b0;
            ack_r         <= 1'b0;
        end else begin
            state_r       <= state_s;
            fade_r        <= fade_s;
            step_cnt_r    <= step_cnt_s;
            hold_cnt_r    <= hold_cnt_s;
            overlay_r     <= overlay_s;
            pend_r        <= pend_s;
            in_play_r     <= in_play_s;
            board_clear_r <= board_clear_s;
            ack_r         <= ack_s;
        end
    end

    assign overlay_on  = overlay_r;
    assign fade_level  = fade_r;
    assign in_play     = in_play_r;
    assign board_clear = board_clear_r;
    assign restart_ack = ack_r;
endmodule

// File: tb/tb_display_seq_ctrl.sv
// Bench for display_seq_ctrl: two instances (FADE_STEP=1 and 3, HOLD_FRAMES=3)
// checked against a frame-counting reference model of the display sequence.
module tb_display_seq_ctrl;
    localparam int HOLD = 3;
    localparam int PH_PLAY = 0, PH_FO = 1, PH_DI = 2, PH_DH = 3, PH_DO = 4, PH_PI = 5;

    logic       dclk = 1'b0;
    logic       clr = 1'b0, frame_start = 1'b0, game_over = 1'b0;
    logic       restart0 = 1'b0, restart1 = 1'b0;
    logic       ov0, ip0, bc0, ack0, ov1, ip1, bc1, ack1;
    logic [3:0] fl0, fl1;
    int         total = 0;
    int         bad = 0;

    // model: phase, frames since phase entry, pending flag, pulses
    int m_ph[2];
    int m_n[2];
    bit m_pend[2];
    bit m_bc[2];
    bit m_ack[2];

    display_seq_ctrl #(.FADE_STEP(1), .HOLD_FRAMES(HOLD)) dut0 (
        .dclk(dclk), .clr(clr), .frame_start(frame_start), .game_over(game_over),
        .restart(restart0), .overlay_on(ov0), .fade_level(fl0), .in_play(ip0),
        .board_clear(bc0), .restart_ack(ack0));

    display_seq_ctrl #(.FADE_STEP(3), .HOLD_FRAMES(HOLD)) dut1 (
        .dclk(dclk), .clr(clr), .frame_start(frame_start), .game_over(game_over),
        .restart(restart1), .overlay_on(ov1), .fade_level(fl1), .in_play(ip1),
        .board_clear(bc1), .restart_ack(ack1));

    always #20 dclk = ~dclk;

    function automatic int fs_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] exp_vec(input int i);
        logic [3:0] lv;
        logic       ov;
        case (m_ph[i])
            PH_FO, PH_DO: lv = 4'(15 - m_n[i] / fs_of(i));
            PH_DI, PH_PI: lv = 4'(m_n[i] / fs_of(i));
            default:      lv = 4'd15;
        endcase
        ov = (m_ph[i] == PH_DI) || (m_ph[i] == PH_DH) || (m_ph[i] == PH_DO);
        return {ov, lv, (m_ph[i] == PH_PLAY), m_bc[i], m_ack[i]};
    endfunction

    function automatic logic [7:0] act_vec(input int i);
        return (i == 0) ? {ov0, fl0, ip0, bc0, ack0} : {ov1, fl1, ip1, bc1, ack1};
    endfunction

    task automatic model_step(input int i, input bit fs, input bit go, input bit rs, input bit cl);
        int len;
        len = 16 * fs_of(i);
        m_bc[i] = 1'b0;
        m_ack[i] = 1'b0;
        if (cl) begin
            m_ph[i] = PH_PLAY;
            m_n[i] = 0;
            m_pend[i] = 1'b0;
        end else begin
            if (rs && (m_ph[i] inside {PH_FO, PH_DI, PH_DH})) m_pend[i] = 1'b1;
            if (fs) begin
                if (m_ph[i] == PH_PLAY) begin
                    if (go) begin
                        m_ph[i] = PH_FO;
                        m_n[i] = 0;
                    end
                end else if (m_ph[i] == PH_DH) begin
                    if (m_n[i] >= HOLD && m_pend[i]) begin
                        m_ph[i] = PH_DO;
                        m_n[i] = 0;
                        m_pend[i] = 1'b0;
                    end else begin
                        m_n[i]++;
                    end
                end else begin
                    m_n[i]++;
                    if (m_n[i] == len) begin
                        m_n[i] = 0;
                        if (m_ph[i] == PH_DO) m_bc[i] = 1'b1;
                        if (m_ph[i] == PH_PI) m_ack[i] = 1'b1;
                        m_ph[i] = (m_ph[i] == PH_PI) ? PH_PLAY : m_ph[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic tick(input bit fs, input bit r0, input bit r1, input bit cl);
        frame_start = fs;
        restart0 = r0;
        restart1 = r1;
        clr = cl;
        @(posedge dclk);
        model_step(0, fs, game_over, r0, cl);
        model_step(1, fs, game_over, r1, cl);
        #1;
        frame_start = 1'b0;
        restart0 = 1'b0;
        restart1 = 1'b0;
        clr = 1'b0;
    endtask

    task automatic frame(input bit r0, input bit r1);
        repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, r0, r1, 1'b0);
    endtask

    task automatic test_reset;
        game_over = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (act_vec(i) !== {1'b0, 4'd15, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset dut%0d got=%b exp=%b", i, act_vec(i), {1'b0, 4'd15, 1'b1, 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_restart_in_play;
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        frame(1'b1, 1'b1);
        frame(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (act_vec(i) !== exp_vec(i)) begin
                bad++;
                $display("FAIL restart_in_play dut%0d got=%b exp=%b", i, act_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_fade_out;
        game_over = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            frame(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== exp_vec(i)) begin
                    bad++;
                    $display("FAIL fade_out dut%0d F%0d got=%b exp=%b", i, k, act_vec(i), exp_vec(i));
                end
            end
            total++;
            if (fl1 !== 4'(15 - (k - 1) / 3) || ov1 !== 1'b0) begin
                bad++;
                $display("FAIL fade_step3 F%0d got=%0d exp=%0d", k, fl1, 15 - (k - 1) / 3);
            end
            if (k == 1) begin
                total++;
                if (fl0 !== 4'd15 || ov0 !== 1'b0 || ip0 !== 1'b0) begin
                    bad++;
                    $display("FAIL fade_f1 got fl=%0d ov=%b ip=%b exp fl=15 ov=0 ip=0", fl0, ov0, ip0);
                end
            end
            if (k == 16) begin
                total++;
                if (fl0 !== 4'd0 || ov0 !== 1'b0) begin
                    bad++;
                    $display("FAIL fade_f16 got fl=%0d ov=%b exp fl=0 ov=0", fl0, ov0);
                end
            end
            if (k == 17) begin
                total++;
                if (fl0 !== 4'd0 || ov0 !== 1'b1) begin
                    bad++;
                    $display("FAIL fade_f17 got fl=%0d ov=%b exp fl=0 ov=1", fl0, ov0);
                end
            end
        end
        game_over = 1'b0;
    endtask

    task automatic test_restart_died_in;
        repeat (3) frame(1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40 && m_ph[0] != PH_DH; k++) begin
            frame(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== exp_vec(i)) begin
                    bad++;
                    $display("FAIL died_in dut%0d got=%b exp=%b", i, act_vec(i), exp_vec(i));
                end
            end
        end
        total++;
        if (m_ph[0] != PH_DH) begin
            bad++;
            $display("FAIL died_in_bound got=phase%0d exp=phase%0d", m_ph[0], PH_DH);
        end
        for (int k = 1; k <= 5; k++) begin
            frame(1'b0, 1'b0);
            total++;
            if (fl0 !== ((k <= 4) ? 4'd15 : 4'd14) || ov0 !== 1'b1) begin
                bad++;
                $display("FAIL hold_len k=%0d got fl=%0d ov=%b exp fl=%0d ov=1", k, fl0, ov0, (k <= 4) ? 15 : 14);
            end
        end
    endtask

    task automatic test_full_cycle;
        int  frames, bc_cnt, ack_cnt, bc_frame, ack_frame;
        bit  prev, fs;
        frames = 0; bc_cnt = 0; ack_cnt = 0; bc_frame = 0; ack_frame = 0; prev = 1'b0;
        for (int c = 0; c < 400 && frames < 40; c++) begin
            fs = !prev && ($urandom_range(0, 1) == 1);
            prev = fs;
            tick(fs, 1'b0, 1'b0, 1'b0);
            if (fs) frames++;
            if (bc0 === 1'b1) begin bc_cnt++; bc_frame = frames; end
            if (ack0 === 1'b1) begin ack_cnt++; ack_frame = frames; end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== exp_vec(i)) begin
                    bad++;
                    $display("FAIL full_cycle dut%0d got=%b exp=%b", i, act_vec(i), exp_vec(i));
                end
            end
        end
        total++;
        if (bc_cnt != 1 || ack_cnt != 1 || ack_frame - bc_frame != 16) begin
            bad++;
            $display("FAIL pulses got bc=%0d ack=%0d gap=%0d exp bc=1 ack=1 gap=16",
                     bc_cnt, ack_cnt, ack_frame - bc_frame);
        end
    endtask

    task automatic test_hold_indefinite;
        for (int k = 0; k < 150 && m_ph[1] != PH_DH; k++) begin
            frame(1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== exp_vec(i)) begin
                    bad++;
                    $display("FAIL to_hold dut%0d got=%b exp=%b", i, act_vec(i), exp_vec(i));
                end
            end
        end
        total++;
        if (m_ph[1] != PH_DH) begin
            bad++;
            $display("FAIL to_hold_bound got=phase%0d exp=phase%0d", m_ph[1], PH_DH);
        end
        for (int k = 0; k < 20; k++) begin
            frame(1'b0, 1'b0);
            total++;
            if (fl1 !== 4'd15 || ov1 !== 1'b1 || ip1 !== 1'b0) begin
                bad++;
                $display("FAIL hold_forever k=%0d got fl=%0d ov=%b exp fl=15 ov=1", k, fl1, ov1);
            end
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            frame(1'b0, 1'b0);
            total++;
            if (fl1 !== ((k < 3) ? 4'd15 : 4'd14) || act_vec(1) !== exp_vec(1)) begin
                bad++;
                $display("FAIL hold_release k=%0d got=%b exp=%b", k, act_vec(1), exp_vec(1));
            end
        end
    endtask

    task automatic test_clr_mid_fade;
        game_over = 1'b1;
        for (int k = 0; k < 30 && !(m_ph[0] == PH_FO && m_n[0] == 8); k++) frame(1'b0, 1'b0);
        total++;
        if (fl0 !== 4'd7 || ov0 !== 1'b0) begin
            bad++;
            $display("FAIL clr_setup got fl=%0d ov=%b exp fl=7 ov=0", fl0, ov0);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        game_over = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== {1'b0, 4'd15, 1'b1, 1'b0, 1'b0}) begin
                    bad++;
                    $display("FAIL clr_abort dut%0d c=%0d got=%b exp=%b", i, c, act_vec(i), {1'b0, 4'd15, 1'b1, 1'b0, 1'b0});
                end
            end
            tick(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random;
        bit prev, fs, r0, r1, cl;
        prev = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) game_over = ~game_over;
            fs = !prev && ($urandom_range(0, 1) == 1);
            prev = fs;
            r0 = ($urandom_range(0, 29) == 0);
            r1 = ($urandom_range(0, 29) == 0);
            cl = ($urandom_range(0, 499) == 0);
            tick(fs, r0, r1, cl);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (act_vec(i) !== exp_vec(i)) begin
                    bad++;
                    $display("FAIL random dut%0d c=%0d got=%b exp=%b", i, c, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = PH_PLAY; m_n[i] = 0; m_pend[i] = 1'b0; m_bc[i] = 1'b0; m_ack[i] = 1'b0;
        end
        #5;
        test_reset();
        test_restart_in_play();
        test_fade_out();
        test_restart_died_in();
        test_full_cycle();
        test_hold_indefinite();
        test_clr_mid_fade();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
